// File: rtl/mem_wb_stage.sv
// Memory-access and register write-back stage: performs one data-memory
// load/store per instruction over a req/ack handshake, then drives the
// register file write port with the ALU result or the loaded word.
module mem_wb_stage #(
    parameter int unsigned DWIDTH  = 32,
    parameter int unsigned RWIDTH  = 6,
    parameter int unsigned AWIDTH  = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              is_load,
    input  logic              is_store,
    input  logic              reg_write,
    input  logic [RWIDTH-1:0] rd,
    input  logic [DWIDTH-1:0] alu_result,
    input  logic [DWIDTH-1:0] store_data,
    output logic              mem_req,
    output logic              mem_we,
    output logic [AWIDTH-1:0] mem_addr,
    output logic [DWIDTH-1:0] mem_wdata,
    input  logic [DWIDTH-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [RWIDTH-1:0] wa,
    output logic [DWIDTH-1:0] wd,
    output logic              we,
    output logic              err
);

    localparam int unsigned CW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MEM  = 2'd1,
        S_WB   = 2'd2
    } state_t;

    state_t            state;
    state_t            next_state;
    logic              accept_c;
    logic              timeout_c;
    logic [CW-1:0]     wait_cnt;
    logic              ld_q;
    logic              rw_q;
    logic [RWIDTH-1:0] rd_q;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode; a late ack on the timeout cycle still wins
    always_comb begin
        next_state = state;
        accept_c   = 1'b0;
        timeout_c  = 1'b0;
        case (state)
            S_IDLE: begin
                if (in_valid) begin
                    accept_c = 1'b1;
                    if (is_load || is_store) begin
                        next_state = S_MEM;
                    end else if (reg_write) begin
                        next_state = S_WB;
                    end
                end
            end
            S_MEM: begin
                if (mem_ack) begin
                    next_state = (ld_q && rw_q) ? S_WB : S_IDLE;
                end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
                    timeout_c  = 1'b1;
                    next_state = S_IDLE;
                end
            end
            S_WB: begin
                next_state = S_IDLE;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    // Holding registers for the accepted instruction and the ack wait counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ld_q      <= 1'b0;
            rw_q      <= 1'b0;
            rd_q      <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_we    <= 1'b0;
            wait_cnt  <= '0;
        end else if (accept_c) begin
            ld_q      <= is_load;
            rw_q      <= reg_write;
            rd_q      <= rd;
            mem_addr  <= alu_result[AWIDTH-1:0];
            mem_wdata <= store_data;
            mem_we    <= is_store & ~is_load;
            wait_cnt  <= '0;
        end else if (state == S_MEM && !mem_ack) begin
            wait_cnt  <= wait_cnt + CW'(1);
        end
    end

    // Registered handshake, write-port and error outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready <= 1'b1;
            mem_req  <= 1'b0;
            we       <= 1'b0;
            err      <= 1'b0;
            wa       <= '0;
            wd       <= '0;
        end else begin
            in_ready <= (next_state == S_IDLE);
            mem_req  <= (next_state == S_MEM);
            we       <= (next_state == S_WB);
            err      <= timeout_c;
            if (next_state == S_WB) begin
                if (state == S_IDLE) begin
                    wa <= rd;
                    wd <= alu_result;
                end else begin
                    wa <= rd_q;
                    wd <= mem_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed vector table, hand-written
// corner sequences and randomized instructions against a transaction model.
module tb_mem_wb_stage;

    localparam int unsigned TO = 16;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        is_load;
    logic        is_store;
    logic        reg_write;
    logic [5:0]  rd;
    logic [31:0] alu_result;
    logic [31:0] store_data;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic [5:0]  wa;
    logic [31:0] wd;
    logic        we;
    logic        err;

    int n_cmp = 0;
    int n_bad = 0;
    int we_cnt = 0;
    int req_cnt = 0;
    int err_cnt = 0;
    int busy_viol = 0;

    mem_wb_stage #(.DWIDTH(32), .RWIDTH(6), .AWIDTH(32), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .is_load(is_load), .is_store(is_store), .reg_write(reg_write), .rd(rd),
        .alu_result(alu_result), .store_data(store_data), .mem_req(mem_req),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .wa(wa), .wd(wd), .we(we), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Event counters sampled with the pre-edge values of each cycle
    always @(posedge clk) begin
        if (rst_n) begin
            if (we) we_cnt++;
            if (mem_req) req_cnt++;
            if (err) err_cnt++;
            if (in_ready && (mem_req || we)) busy_viol++;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Write-back cycle followed by the return to idle
    task automatic expect_wb(input logic [5:0] r, input logic [31:0] d);
        chk("wb_we", 64'(we), 64'(1));
        chk("wb_wa", 64'(wa), 64'(r));
        chk("wb_wd", 64'(wd), 64'(d));
        chk("wb_ready", 64'(in_ready), 64'(0));
        chk("wb_req", 64'(mem_req), 64'(0));
        @(negedge clk);
        chk("post_wb_we", 64'(we), 64'(0));
        chk("post_wb_ready", 64'(in_ready), 64'(1));
        chk("wd_hold", 64'(wd), 64'(d));
    endtask

    // One instruction from idle; lat = cycle of MEM that sees ack (0 = never)
    task automatic run_instr(input logic ld, input logic st, input logic rw,
                             input logic [5:0] r, input logic [31:0] a,
                             input logic [31:0] s, input logic [31:0] rdat,
                             input int lat);
        bit mem_op;
        bit acked;
        bit tmo;
        int c;
        mem_op = ld | st;
        acked  = 1'b0;
        tmo    = 1'b0;
        chk("ready_idle", 64'(in_ready), 64'(1));
        is_load = ld; is_store = st; reg_write = rw; rd = r;
        alu_result = a; store_data = s; in_valid = 1'b1; mem_ack = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        is_load = 1'($urandom); is_store = 1'($urandom); reg_write = 1'($urandom);
        rd = 6'($urandom); alu_result = $urandom; store_data = $urandom;
        if (mem_op) begin
            c = 1;
            while (!acked && !tmo) begin
                chk("mem_req", 64'(mem_req), 64'(1));
                chk("mem_addr", 64'(mem_addr), 64'(a));
                chk("mem_we", 64'(mem_we), 64'(!ld));
                chk("mem_wdata", 64'(mem_wdata), 64'(s));
                chk("ready_busy", 64'(in_ready), 64'(0));
                chk("we_in_mem", 64'(we), 64'(0));
                chk("err_in_mem", 64'(err), 64'(0));
                acked = (c == lat);
                mem_ack = acked;
                mem_rdata = acked ? rdat : $urandom;
                @(negedge clk);
                mem_ack = 1'b0;
                if (!acked && c == int'(TO)) tmo = 1'b1;
                c++;
            end
            if (tmo) begin
                chk("tmo_err", 64'(err), 64'(1));
                chk("tmo_req", 64'(mem_req), 64'(0));
                chk("tmo_we", 64'(we), 64'(0));
                chk("tmo_ready", 64'(in_ready), 64'(1));
                @(negedge clk);
                chk("tmo_err_pulse", 64'(err), 64'(0));
            end else if (ld && rw) begin
                expect_wb(r, rdat);
            end else begin
                chk("ack_req_drop", 64'(mem_req), 64'(0));
                chk("ack_no_we", 64'(we), 64'(0));
                chk("ack_ready", 64'(in_ready), 64'(1));
                chk("ack_no_err", 64'(err), 64'(0));
            end
        end else if (rw) begin
            expect_wb(r, a);
        end else begin
            chk("nop_ready", 64'(in_ready), 64'(1));
            chk("nop_we", 64'(we), 64'(0));
            chk("nop_req", 64'(mem_req), 64'(0));
        end
    endtask

    typedef struct {
        logic        ld;
        logic        st;
        logic        rw;
        logic [5:0]  r;
        logic [31:0] a;
        logic [31:0] s;
        logic [31:0] rdat;
        int          lat;
        int          exp_we;
        int          exp_req;
        int          exp_err;
        logic [31:0] exp_wd;
    } vec_t;

    vec_t vecs[9];

    typedef struct {
        logic        ld;
        logic [5:0]  r;
        logic [31:0] a;
    } op_t;

    op_t ops[8];

    initial begin
        int w0, q0, e0, idx, reqc, nloads;
        bit acc;
        vecs[0] = '{1'b0, 1'b0, 1'b1, 6'd5,  32'h0000_1234, 32'h0,         32'h0,         0,  1, 0,  0, 32'h0000_1234};
        vecs[1] = '{1'b1, 1'b0, 1'b1, 6'd7,  32'h0000_0040, 32'h0,         32'hDEAD_BEEF, 3,  1, 3,  0, 32'hDEAD_BEEF};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 6'd2,  32'h0000_0080, 32'hCAFE_F00D, 32'h0,         1,  0, 1,  0, 32'h0};
        vecs[3] = '{1'b1, 1'b0, 1'b1, 6'd9,  32'h0000_0100, 32'h0,         32'h0,         0,  0, 16, 1, 32'h0};
        vecs[4] = '{1'b1, 1'b0, 1'b1, 6'd10, 32'h0000_0104, 32'h0,         32'h1111_2222, 16, 1, 16, 0, 32'h1111_2222};
        vecs[5] = '{1'b1, 1'b1, 1'b1, 6'd11, 32'h0000_0200, 32'h7777_7777, 32'h5A5A_A5A5, 2,  1, 2,  0, 32'h5A5A_A5A5};
        vecs[6] = '{1'b0, 1'b0, 1'b0, 6'd12, 32'h0000_0300, 32'h0,         32'h0,         0,  0, 0,  0, 32'h0};
        vecs[7] = '{1'b0, 1'b1, 1'b1, 6'd13, 32'h0000_0400, 32'h1234_5678, 32'h0,         2,  0, 2,  0, 32'h0};
        vecs[8] = '{1'b1, 1'b0, 1'b0, 6'd14, 32'h0000_0500, 32'h0,         32'h9999_0000, 1,  0, 1,  0, 32'h0};

        rst_n = 1'b0; in_valid = 1'b0; is_load = 1'b0; is_store = 1'b0; reg_write = 1'b0;
        rd = '0; alu_result = '0; store_data = '0; mem_rdata = '0; mem_ack = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready", 64'(in_ready), 64'(1));
        chk("rst_req", 64'(mem_req), 64'(0));
        chk("rst_mem_we", 64'(mem_we), 64'(0));
        chk("rst_addr", 64'(mem_addr), 64'(0));
        chk("rst_wdata", 64'(mem_wdata), 64'(0));
        chk("rst_wa", 64'(wa), 64'(0));
        chk("rst_wd", 64'(wd), 64'(0));
        chk("rst_we", 64'(we), 64'(0));
        chk("rst_err", 64'(err), 64'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // Directed vector table
        for (int i = 0; i < 9; i++) begin
            w0 = we_cnt; q0 = req_cnt; e0 = err_cnt;
            run_instr(vecs[i].ld, vecs[i].st, vecs[i].rw, vecs[i].r, vecs[i].a,
                      vecs[i].s, vecs[i].rdat, vecs[i].lat);
            chk($sformatf("vec%0d_we_count", i), 64'(we_cnt - w0), 64'(vecs[i].exp_we));
            chk($sformatf("vec%0d_req_cycles", i), 64'(req_cnt - q0), 64'(vecs[i].exp_req));
            chk($sformatf("vec%0d_err_count", i), 64'(err_cnt - e0), 64'(vecs[i].exp_err));
            if (vecs[i].exp_we != 0)
                chk($sformatf("vec%0d_wd", i), 64'(wd), 64'(vecs[i].exp_wd));
        end

        // Ack while idle has no effect
        mem_ack = 1'b1; mem_rdata = 32'hFFFF_0000;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("idle_ack_req", 64'(mem_req), 64'(0));
        chk("idle_ack_we", 64'(we), 64'(0));
        chk("idle_ack_ready", 64'(in_ready), 64'(1));

        // Reset asserted in the middle of a load
        w0 = we_cnt;
        is_load = 1'b1; is_store = 1'b0; reg_write = 1'b1; rd = 6'd9;
        alu_result = 32'h0000_0900; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("pre_rst_req", 64'(mem_req), 64'(1));
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_req", 64'(mem_req), 64'(0));
        chk("abort_we", 64'(we), 64'(0));
        chk("abort_ready", 64'(in_ready), 64'(1));
        chk("abort_addr", 64'(mem_addr), 64'(0));
        mem_ack = 1'b1; mem_rdata = 32'hBAD0_BAD0;
        @(negedge clk);
        rst_n = 1'b1; mem_ack = 1'b0;
        @(negedge clk);
        chk("after_abort_we", 64'(we), 64'(0));
        chk("after_abort_req", 64'(mem_req), 64'(0));
        chk("abort_no_write", 64'(we_cnt - w0), 64'(0));
        run_instr(1'b0, 1'b0, 1'b1, 6'd3, 32'h0000_ABCD, 32'h0, 32'h0, 0);
        chk("after_abort_alu_count", 64'(we_cnt - w0), 64'(1));

        // in_valid held high with alternating ALU and load ops
        nloads = 0;
        for (int i = 0; i < 8; i++) begin
            ops[i].ld = (i % 2 == 1) ? 1'b1 : 1'b0;
            ops[i].r  = 6'(i + 20);
            ops[i].a  = 32'h100 * 32'(i);
            if (ops[i].ld) nloads++;
        end
        w0 = we_cnt; q0 = req_cnt;
        idx = 0; reqc = 0;
        for (int cyc = 0; cyc < 300 && idx < 8; cyc++) begin
            if (mem_req) begin
                reqc++;
                mem_ack = (reqc == 2);
                mem_rdata = $urandom;
            end else begin
                reqc = 0;
                mem_ack = 1'b0;
            end
            in_valid = 1'b1; is_load = ops[idx].ld; is_store = 1'b0; reg_write = 1'b1;
            rd = ops[idx].r; alu_result = ops[idx].a;
            acc = in_ready;
            @(negedge clk);
            if (acc) idx++;
        end
        chk("stream_all_accepted", 64'(idx), 64'(8));
        in_valid = 1'b0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            if (mem_req) begin
                reqc++;
                mem_ack = (reqc == 2);
            end else begin
                reqc = 0;
                mem_ack = 1'b0;
            end
            @(negedge clk);
        end
        mem_ack = 1'b0;
        chk("stream_we_count", 64'(we_cnt - w0), 64'(8));
        chk("stream_req_cycles", 64'(req_cnt - q0), 64'(2 * nloads));
        chk("stream_idle_at_end", 64'(in_ready), 64'(1));

        // Randomized instructions against the transaction model
        for (int i = 0; i < 40; i++) begin
            int sel, lat;
            sel = int'($urandom_range(0, 9));
            if (sel < 6)      lat = int'($urandom_range(1, 4));
            else if (sel < 8) lat = 0;
            else              lat = int'($urandom_range(14, 17));
            run_instr(1'($urandom), 1'($urandom), 1'($urandom), 6'($urandom),
                      $urandom, $urandom, $urandom, lat);
        end

        chk("busy_never_ready", 64'(busy_viol), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

Memory-access and register write-back stage that closes the loop on the register-file/ALU block. It accepts one executed instruction at a time (ALU result, store data, destination register, control bits) and performs the data-memory load or store over a req/ack handshake. It then drives the register file's write port (`wa`, `wd`, `we`) with either the ALU result or the loaded word. It is the writer side of the register file, whose read side feeds the ALU.

## Interface
Parameters:
- `DWIDTH`, 32, data and ALU result width
- `RWIDTH`, 6, register address width (64 registers)
- `AWIDTH`, 32, data-memory address width, taken from `alu_result[AWIDTH-1:0]`
- `TIMEOUT`, 16, maximum cycles to wait for `mem_ack` (≥2)

Ports:
- `clk` in 1: single clock, all state on rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `in_valid` in 1: instruction presented
- `in_ready` out 1: stage can accept
- `is_load` in 1: instruction reads data memory
- `is_store` in 1: instruction writes data memory (`is_load` wins if both are set)
- `reg_write` in 1: instruction writes a register
- `rd` in RWIDTH: destination register
- `alu_result` in DWIDTH: ALU result, also the memory address
- `store_data` in DWIDTH: register operand B, store payload
- `mem_req` out 1: memory request
- `mem_we` out 1: 1 = store, 0 = load
- `mem_addr` out AWIDTH: request address
- `mem_wdata` out DWIDTH: store data
- `mem_rdata` in DWIDTH: load data, valid with `mem_ack`
- `mem_ack` in 1: request completed
- `wa` out RWIDTH: register file write address
- `wd` out DWIDTH: register file write data
- `we` out 1: register file write enable, one-cycle pulse
- `err` out 1: one-cycle pulse on memory timeout

## Operation
- States:
  - IDLE: `in_ready`=1.
  - MEM: request outstanding.
  - WB: write-back cycle.
- Accept on `in_valid && in_ready` at a rising edge. Latch all inputs into holding registers. Inputs are ignored at every other time.
- From IDLE, after accept:
  - load or store → MEM.
  - else if `reg_write` → WB.
  - else stay in IDLE (instruction retires with no effect).
- In MEM:
  - `mem_req`=1, with `mem_addr`/`mem_we`/`mem_wdata` stable from latched values until ack.
  - `mem_ack` sampled high:
    - Load: capture `mem_rdata`, go to WB if latched `reg_write`=1, else IDLE.
    - Store: go to IDLE.
  - Wait counter increments on every MEM cycle without ack. When it reaches TIMEOUT-1 with no ack: go to IDLE, pulse `err`, no register write.
- In WB:
  - `we`=1, `wa`=latched `rd`.
  - `wd` = captured load data for loads, latched `alu_result` otherwise.
  - Always returns to IDLE.
- Register 0 is not special-cased; the register file defines its semantics.
- `mem_ack` outside MEM is ignored.

## Timing
- Reset (async assert, sync release):
  - State = IDLE; `in_ready`=1.
  - `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0.
  - `wa`=0, `wd`=0, `we`=0, `err`=0; wait counter = 0.
- Non-memory op accepted at edge N: `we` high for the cycle after edge N. `in_ready`=0 in that cycle, 1 after edge N+1. Throughput is one instruction per 2 cycles.
- Memory op accepted at edge N:
  - `mem_req` rises after edge N.
  - Ack sampled at edge N+k (k≥1): load write-back `we` is high in the cycle after edge N+k.
  - Best load latency is 2 cycles accept→`we`; best store is IDLE again after 1 cycle.
- `mem_req` deasserts in the cycle after the ack edge. Back-to-back requests always have ≥1 idle cycle of `mem_req`=0.
- Timeout: `mem_req` is high for exactly TIMEOUT cycles, then `err` pulses for 1 cycle concurrent with the return to IDLE.
- Ack arriving on the same edge as the timeout count is reached: ack wins, and there is no `err`.
- `rst_n` asserted mid-MEM or mid-WB: immediate abort, outputs at reset values. No write is issued.
- `wa`/`wd` hold their last values outside WB; only `we` qualifies them.

## Test plan
- Reset, then ALU op (`rd`=5, `alu_result`=0x0000_1234, `reg_write`=1) → `we`=1 for exactly one cycle, `wa`=5, `wd`=0x0000_1234, `mem_req` never asserted.
- Load (`rd`=7, `alu_result`=0x40) with `mem_ack` after 3 cycles, `mem_rdata`=0xDEAD_BEEF → `mem_req` high 3 cycles with `mem_addr`=0x40 and `mem_we`=0; then `we`=1, `wa`=7, `wd`=0xDEAD_BEEF.
- Store (`alu_result`=0x80, `store_data`=0xCAFE_F00D), ack in first cycle → one cycle of `mem_req`=1, `mem_we`=1, `mem_wdata`=0xCAFE_F00D; `we` stays 0; `in_ready` back to 1 next cycle.
- Load with no ack, TIMEOUT=16 → `mem_req` high exactly 16 cycles, `err` pulses once, no `we`. Repeat with ack on cycle 16 → no `err`, write-back occurs.
- `rst_n` pulsed low during MEM of a load → `mem_req` drops immediately, no `we`. A subsequent ALU op writes back normally.
- `in_valid` held high with alternating ALU/load ops → no instruction dropped or duplicated: `we` count equals accepted `reg_write` instructions, and `in_ready`=0 whenever busy.
